data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Data-side memory controller that sits directly downstream of the RV32I core's load/store port (req_mem, wmem_o, wmask, addr_o, data_o → data_i, data_stall, data_err).
- Replaces the zero-latency behavioural byte array with a synthesizable, byte-addressed local RAM.
- Inserts a programmable number of wait states, raising data_stall while it waits.
- Flags out-of-range or malformed accesses on data_err.

Parameters:
- DEPTH, 4096, RAM size in bytes; must be a power of two and at least 4.
- WAIT_CYCLES, 0, wait states per access, range 0..15; 0 gives single-cycle behaviour with no stall.
- AW, $clog2(DEPTH), internal byte-address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_mem  in  1  core access request; held by the core while data_stall=1.
- wmem_i  in  1  1 = store, 0 = load.
- wmask_i  in  4  byte-lane write enables, lane0 = addr+0.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, little-endian lanes.
- rdata_o  out  32  load data: {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
- data_stall  out  1  access not yet complete; core must hold its request.
- data_err  out  1  access fault, valid in the completion cycle only.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE, wait counter = 0, latched request registers = 0.
  - data_stall=0, data_err=0, rdata_o=0.
  - RAM byte i is initialised to i[7:0], matching the current bench memory image.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - req_mem=0 → stay, stall=0.
  - req_mem=1 with WAIT_CYCLES=0 → the access completes in the same cycle: stall=0, rdata_o combinational, store commits at the next edge, stay in IDLE.
  - req_mem=1 with WAIT_CYCLES>0 → stall=1 combinationally in that cycle; latch addr, wdata, wmask and we; load counter = WAIT_CYCLES-1; go to WAIT.
- WAIT:
  - stall=1; the counter decrements each cycle.
  - counter==0 → go to DONE.
- DONE:
  - stall=0 for exactly one cycle; rdata_o is driven from the latched address.
  - A store commits at this edge using the latched wmask.
  - Return to IDLE; a new request is not accepted in the DONE cycle.
- Total latency: WAIT_CYCLES stall cycles, then one completion cycle.
- Error detection (evaluated on the effective address: addr_i in IDLE, the latched copy otherwise):
  - addr[31:AW] != 0, or addr[AW-1:0] > DEPTH-4 → range error.
  - Store with wmask not in {0001,0010,0100,1000,0011,1100,1111} → mask error.
  - On either error in the completion cycle: data_err=1, rdata_o=0, no RAM write.
  - The wait-state timing is identical for error and non-error accesses.
- Abort: req_mem falling to 0 while in WAIT → go to IDLE next cycle, no write, data_err=0.
- Load with wmask≠0 → wmask is ignored.
- Store with wmask=0 → completes with no write and no error.
- Reset asserted mid-WAIT → the access is dropped; the RAM contents are re-initialised.
- rdata_o for a store completion returns the pre-write contents.

Optional Feature:
- Macro: DMEM_RAND_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances on every accepted request.
  - The wait count for that access = lfsr[3:0] mod (WAIT_CYCLES+1).
  - A result of 0 takes the zero-wait path.
- When undefined: fixed WAIT_CYCLES and no LFSR logic.

Decomposition:
- Package dmem_pkg holds:
  - The FSM state enum {IDLE, WAIT, DONE}.
  - The legal-wmask constant list.
  - The LFSR seed and tap constants.
  - A function is_legal_mask(logic [3:0]).
- One sub-module, dmem_byte_ram:
  - Four byte lanes, write-masked write port, asynchronous read.
  - Reset initialisation logic.
- The FSM, counter, error check and LFSR stay in the top level.

Test Plan:
- WAIT_CYCLES=0, load at addr 0x100 → same cycle rdata_o=32'h03020100, stall never asserted.
- WAIT_CYCLES=3:
  - Store 32'hDEADBEEF with wmask 1111 at 0x200 → stall high for 3 cycles then low for 1.
  - Load at 0x200 → rdata_o=32'hDEADBEEF after 3 stall cycles.
- Store byte 8'h5A with wmask 0010 at 0x300 → load at 0x300 returns 32'h03025A00; other lanes unchanged.
- Load at 0xFFE (DEPTH=4096), and separately a store with wmask 0101 → data_err=1 for one cycle, rdata_o=0, RAM unchanged.
- Reset and abort:
  - reset=0 asserted during WAIT of a store to 0x10 → after release, load at 0x10 returns 32'h13121110; stall=0 immediately after reset.
  - req_mem dropped during WAIT → the controller is in IDLE the following cycle with no write.
- With DMEM_RAND_STALL_EN, WAIT_CYCLES=7, 100 random accesses:
  - Every stall length is ≤7.
  - Read-back matches a reference byte model.
  - At least two distinct stall lengths are observed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory controller.
//   - state_t        : controller FSM states (IDLE, WAIT, DONE)
//   - LEGAL_MASKS    : store byte-enable patterns that are accepted
//   - LFSR_SEED/TAPS : constants for the optional random wait-state LFSR
//   - is_legal_mask  : membership test against LEGAL_MASKS
//   - lfsr_next      : one step of the 8-bit Fibonacci LFSR
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_LEGAL_MASKS = 7;

    // Byte, aligned halfword and word lane patterns.
    localparam logic [3:0] LEGAL_MASKS [NUM_LEGAL_MASKS] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111
    };

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic is_legal_mask(input logic [3:0] mask);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_MASKS; i++) begin
            if (mask == LEGAL_MASKS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Feedback is the parity of the tapped bits, shifted in at the LSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core load/store port bundle.
//   master : core side   (drives req_mem, wmem_i, wmask_i, addr_i, wdata_i)
//   slave  : memory side (drives rdata_o, data_stall, data_err)
interface dmem_if;
    logic        req_mem;
    logic        wmem_i;
    logic [3:0]  wmask_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        data_stall;
    logic        data_err;

    modport master (
        output req_mem, wmem_i, wmask_i, addr_i, wdata_i,
        input  rdata_o, data_stall, data_err
    );

    modport slave (
        input  req_mem, wmem_i, wmask_i, addr_i, wdata_i,
        output rdata_o, data_stall, data_err
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// Byte-addressed local RAM with four byte lanes.
//   clk, reset : clock, asynchronous active-low reset (reloads byte i with i[7:0])
//   we, wmask  : write enable and per-lane enables (lane k writes addr+k)
//   addr       : byte address of lane 0
//   wdata      : little-endian write data
//   rdata      : asynchronous read {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}
// Lanes are relative to addr, so unaligned accesses need no rotation.
module dmem_byte_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem_r [DEPTH];

    // Byte storage: reset image plus masked lane writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'(i);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we && wmask[k]) begin
                    mem_r[addr + AW'(k)] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = {mem_r[addr + AW'(3)], mem_r[addr + AW'(2)],
                    mem_r[addr + AW'(1)], mem_r[addr]};

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller for the core load/store port.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : dmem_if.slave (request in, rdata_o/data_stall/data_err out)
// Parameters: DEPTH (bytes, power of two >= 4), WAIT_CYCLES (0..15), AW.
// Optional macro DMEM_RAND_STALL_EN: per-access wait count drawn from an
// 8-bit LFSR as lfsr[3:0] mod (WAIT_CYCLES+1); otherwise fixed WAIT_CYCLES.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_wdata_r;
    logic [3:0]  lat_wmask_r;
    logic        lat_we_r;

    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic [3:0]  eff_wmask_s;
    logic        eff_we_s;
    logic        range_err_s;
    logic        mask_err_s;
    logic        err_s;
    logic [3:0]  wait_n_s;
    logic        stall_s;
    logic        complete_s;
    logic        latch_s;
    logic        ram_we_s;
    logic [31:0] ram_rdata_s;

`ifdef DMEM_RAND_STALL_EN
    logic [7:0]  lfsr_r;
    logic [4:0]  wait_mod_s;

    // Random wait count for the request presented this cycle.
    always_comb begin
        wait_mod_s = {1'b0, lfsr_r[3:0]} % 5'(WAIT_CYCLES + 1);
        wait_n_s   = wait_mod_s[3:0];
    end

    // LFSR steps once per accepted request, including zero-wait ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (state_r == IDLE && bus.req_mem) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign wait_n_s = 4'(WAIT_CYCLES);
`endif

    // Effective request: live inputs in IDLE, latched copy in WAIT/DONE.
    always_comb begin
        if (state_r == IDLE) begin
            eff_addr_s  = bus.addr_i;
            eff_wdata_s = bus.wdata_i;
            eff_wmask_s = bus.wmask_i;
            eff_we_s    = bus.wmem_i;
        end else begin
            eff_addr_s  = lat_addr_r;
            eff_wdata_s = lat_wdata_r;
            eff_wmask_s = lat_wmask_r;
            eff_we_s    = lat_we_r;
        end
    end

    // Fault detection; an all-zero store mask is a legal no-op.
    always_comb begin
        range_err_s = (eff_addr_s[31:AW] != '0) ||
                      (eff_addr_s[AW-1:0] > AW'(DEPTH - 4));
        mask_err_s  = eff_we_s && (eff_wmask_s != 4'b0000) &&
                      !is_legal_mask(eff_wmask_s);
        err_s       = range_err_s || mask_err_s;
    end

    // Next-state and handshake. cnt_r holds the stall cycles still owed
    // after the current one, so an access stalls exactly wait_n_s cycles
    // (accept cycle included) before its single completion cycle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        latch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_mem) begin
                    if (wait_n_s == 4'd0) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        latch_s = 1'b1;
                        cnt_s   = wait_n_s - 4'd1;
                        state_s = (wait_n_s == 4'd1) ? DONE : WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                if (!bus.req_mem) begin
                    // Core withdrew the request: drop it without side effects.
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_s = DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                complete_s = 1'b1;
                state_s    = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture at acceptance of a stalled access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            lat_wmask_r <= 4'd0;
            lat_we_r    <= 1'b0;
        end else if (latch_s) begin
            lat_addr_r  <= bus.addr_i;
            lat_wdata_r <= bus.wdata_i;
            lat_wmask_r <= bus.wmask_i;
            lat_we_r    <= bus.wmem_i;
        end else begin
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
            lat_wmask_r <= lat_wmask_r;
            lat_we_r    <= lat_we_r;
        end
    end

    assign ram_we_s = complete_s && eff_we_s && !err_s;

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_s),
        .wmask (eff_wmask_s),
        .addr  (eff_addr_s[AW-1:0]),
        .wdata (eff_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Response: read data (pre-write for stores) only in a clean completion.
    always_comb begin
        bus.data_stall = stall_s;
        bus.data_err   = complete_s && err_s;
        if (complete_s && !err_s) begin
            bus.rdata_o = ram_rdata_s;
        end else begin
            bus.rdata_o = 32'd0;
        end
    end

endmodule
